// File: rtl/vga_dtg_if.sv
// ---------------------------------------------------------------------------
// vga_dtg_if
//  Groups the display-timing outputs of vga_dtg so they can be handed to the
//  icon / world-map lookup stages and the colorizer as one bundle.
//
//  Signals:
//    horiz_sync    horizontal sync (active level set by the generator)
//    vert_sync     vertical sync
//    video_on      1 inside the visible window
//    pixel_column  horizontal scan position, 12 bits
//    pixel_row     vertical scan position, 12 bits
//    frame_start   one-cycle pulse while the bundle shows (0,0)
//    frame_count   16-bit frame counter, present only with DTG_FRAME_COUNT_EN
//
//  Modports: master = timing generator (drives), slave = consumers (read).
//  Optional feature macro: DTG_FRAME_COUNT_EN.
// ---------------------------------------------------------------------------
interface vga_dtg_if;
    logic        horiz_sync;
    logic        vert_sync;
    logic        video_on;
    logic [11:0] pixel_column;
    logic [11:0] pixel_row;
    logic        frame_start;
`ifdef DTG_FRAME_COUNT_EN
    logic [15:0] frame_count;
`endif

    modport master (
        output horiz_sync,
        output vert_sync,
        output video_on,
        output pixel_column,
        output pixel_row,
`ifdef DTG_FRAME_COUNT_EN
        output frame_count,
`endif
        output frame_start
    );

    modport slave (
        input horiz_sync,
        input vert_sync,
        input video_on,
        input pixel_column,
        input pixel_row,
`ifdef DTG_FRAME_COUNT_EN
        input frame_count,
`endif
        input frame_start
    );
endinterface

// File: rtl/vga_dtg.sv
// ---------------------------------------------------------------------------
// vga_dtg
//  Display timing generator for the 1024x768@60Hz VGA path (65 MHz pixel
//  clock). Free-running horizontal/vertical counters are decoded into sync,
//  active-video and frame-start qualifiers; every output is registered from
//  the decode of the current counters, so all outputs lag the counters by one
//  cycle and stay mutually aligned.
//
//  Ports:
//    clock     in   pixel clock
//    reset_n   in   asynchronous active-low reset
//    vga       vga_dtg_if.master: horiz_sync, vert_sync, video_on,
//              pixel_column[11:0], pixel_row[11:0], frame_start
//              (+ frame_count[15:0] when DTG_FRAME_COUNT_EN is defined)
//
//  Optional feature macro: DTG_FRAME_COUNT_EN (adds frame_count).
// ---------------------------------------------------------------------------
module vga_dtg #(
    parameter int H_ACTIVE = 1024,
    parameter int H_FRONT  = 24,
    parameter int H_SYNC   = 136,
    parameter int H_BACK   = 160,
    parameter int V_ACTIVE = 768,
    parameter int V_FRONT  = 3,
    parameter int V_SYNC   = 6,
    parameter int V_BACK   = 29,
    parameter bit SYNC_POL = 1'b0
) (
    input  logic      clock,
    input  logic      reset_n,
    vga_dtg_if.master vga
);
    localparam int H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;

    localparam logic [11:0] C_H_LAST   = 12'(H_TOTAL - 1);
    localparam logic [11:0] C_H_ACTIVE = 12'(H_ACTIVE);
    localparam logic [11:0] C_HS_BEGIN = 12'(H_ACTIVE + H_FRONT);
    localparam logic [11:0] C_HS_END   = 12'(H_ACTIVE + H_FRONT + H_SYNC);
    localparam logic [11:0] C_V_LAST   = 12'(V_TOTAL - 1);
    localparam logic [11:0] C_V_ACTIVE = 12'(V_ACTIVE);
    localparam logic [11:0] C_VS_BEGIN = 12'(V_ACTIVE + V_FRONT);
    localparam logic [11:0] C_VS_END   = 12'(V_ACTIVE + V_FRONT + V_SYNC);

    logic [11:0] r_hc;
    logic [11:0] r_vc;

    logic        w_h_wrap;
    logic        w_v_wrap;
    logic        w_video_on;
    logic        w_hs_active;
    logic        w_vs_active;
    logic        w_frame_start;

    logic        r_horiz_sync;
    logic        r_vert_sync;
    logic        r_video_on;
    logic [11:0] r_pixel_column;
    logic [11:0] r_pixel_row;
    logic        r_frame_start;

    assign w_h_wrap      = (r_hc == C_H_LAST);
    assign w_v_wrap      = (r_vc == C_V_LAST);
    assign w_video_on    = (r_hc < C_H_ACTIVE) && (r_vc < C_V_ACTIVE);
    assign w_hs_active   = (r_hc >= C_HS_BEGIN) && (r_hc < C_HS_END);
    // Depends on vc only, so it can only change where hc wraps to 0.
    assign w_vs_active   = (r_vc >= C_VS_BEGIN) && (r_vc < C_VS_END);
    assign w_frame_start = (r_hc == 12'd0) && (r_vc == 12'd0);

    // Scan counters: vc advances only on the line wrap.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_hc <= 12'd0;
            r_vc <= 12'd0;
        end else if (w_h_wrap) begin
            r_hc <= 12'd0;
            r_vc <= w_v_wrap ? 12'd0 : r_vc + 12'd1;
        end else begin
            r_hc <= r_hc + 12'd1;
        end
    end

    // Registered decode: one cycle behind the counters, all aligned.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_horiz_sync   <= ~SYNC_POL;
            r_vert_sync    <= ~SYNC_POL;
            r_video_on     <= 1'b0;
            r_pixel_column <= 12'd0;
            r_pixel_row    <= 12'd0;
            r_frame_start  <= 1'b0;
        end else begin
            r_horiz_sync   <= w_hs_active ? SYNC_POL : ~SYNC_POL;
            r_vert_sync    <= w_vs_active ? SYNC_POL : ~SYNC_POL;
            r_video_on     <= w_video_on;
            r_pixel_column <= r_hc;
            r_pixel_row    <= r_vc;
            r_frame_start  <= w_frame_start;
        end
    end

    assign vga.horiz_sync   = r_horiz_sync;
    assign vga.vert_sync    = r_vert_sync;
    assign vga.video_on     = r_video_on;
    assign vga.pixel_column = r_pixel_column;
    assign vga.pixel_row    = r_pixel_row;
    assign vga.frame_start  = r_frame_start;

`ifdef DTG_FRAME_COUNT_EN
    // Steps on the same edge that raises frame_start, so the first frame
    // after reset reads 1. Natural 16-bit wrap.
    logic [15:0] r_frame_count;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_frame_count <= 16'd0;
        end else if (w_frame_start) begin
            r_frame_count <= r_frame_count + 16'd1;
        end
    end

    assign vga.frame_count = r_frame_count;
`endif

endmodule
